// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// The fetch lookup is combinational from registered state. Resolved
// control-flow instructions from EX update at most one entry per cycle.
// A saturating counter records how many predictions turned out wrong.
module bpred_btb #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_pc,
   output logic            p_hit,
   output logic            p_taken,
   output logic [XLEN-1:0] p_target,
   input  logic            u_valid,
   input  logic [XLEN-1:0] u_pc,
   input  logic            u_is_branch,
   input  logic            u_is_jump,
   input  logic            u_taken,
   input  logic [XLEN-1:0] u_target,
   input  logic            u_pred_taken,
   input  logic [XLEN-1:0] u_pred_target,
   output logic            u_mispredict,
   input  logic            flush_all,
   output logic [15:0]     mispred_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - 2 - IDX_W;
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

   // Table state
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic             jmp_q    [ENTRIES];

   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [XLEN-1:0]  target_d [ENTRIES];
   logic [1:0]       ctr_d    [ENTRIES];
   logic             jmp_d    [ENTRIES];

   logic [15:0]      mispred_cnt_q;
   logic [15:0]      mispred_cnt_d;

   // Address split; the low two PC bits never take part in indexing or tags
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             unused_pc_lsbs;

   assign f_idx          = f_pc[IDX_W+1:2];
   assign f_tag          = f_pc[XLEN-1:IDX_W+2];
   assign u_idx          = u_pc[IDX_W+1:2];
   assign u_tag          = u_pc[XLEN-1:IDX_W+2];
   assign unused_pc_lsbs = ^{f_pc[1:0], u_pc[1:0]};

   // Single write port contents
   logic             upd_en;
   logic             upd_hit;
   logic             wr_en;
   logic [TAG_W-1:0] wr_tag;
   logic [XLEN-1:0]  wr_target;
   logic [1:0]       wr_ctr;
   logic             wr_jmp;

   // Lookup: reads registered state only, so a same-cycle update is not visible
   always_comb begin
      p_hit    = f_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
      p_taken  = p_hit & (jmp_q[f_idx] | ctr_q[f_idx][1]);
      p_target = p_taken ? target_q[f_idx] : (f_pc + PC_INC);
   end

   // Mispredict detection; a wrong target only matters when the branch was taken
   always_comb begin
      u_mispredict = u_valid & ((u_pred_taken != u_taken) |
                                (u_taken & (u_pred_target != u_target)));
   end

   // Decide what, if anything, the single write port stores this cycle.
   // Jump wins when both type flags are set.
   always_comb begin
      upd_en    = u_valid & (u_is_branch | u_is_jump);
      upd_hit   = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
      wr_en     = 1'b0;
      wr_tag    = tag_q[u_idx];
      wr_target = target_q[u_idx];
      wr_ctr    = ctr_q[u_idx];
      wr_jmp    = jmp_q[u_idx];
      if (upd_en) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (u_is_jump) begin
               wr_ctr    = 2'b11;
               wr_jmp    = 1'b1;
               wr_target = u_target;
            end else begin
               if (u_taken) begin
                  wr_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
                  wr_target = u_target;
               end else begin
                  wr_ctr = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
               end
            end
         end else if (u_taken) begin
            // Allocate (or evict whatever lives at this index)
            wr_en     = 1'b1;
            wr_tag    = u_tag;
            wr_target = u_target;
            wr_jmp    = u_is_jump;
            wr_ctr    = u_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

   // Next table state: a flush invalidates everything and drops the update
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_d[i]  = flush_all ? 1'b0 : valid_q[i];
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
         jmp_d[i]    = jmp_q[i];
      end
      if (wr_en && !flush_all) begin
         valid_d[u_idx]  = 1'b1;
         tag_d[u_idx]    = wr_tag;
         target_d[u_idx] = wr_target;
         ctr_d[u_idx]    = wr_ctr;
         jmp_d[u_idx]    = wr_jmp;
      end
   end

   // Mispredict counter saturates at all ones; flushed updates still count
   always_comb begin
      mispred_cnt_d = mispred_cnt_q;
      if (u_mispredict && (mispred_cnt_q != 16'hFFFF)) begin
         mispred_cnt_d = mispred_cnt_q + 16'd1;
      end
   end

   assign mispred_cnt = mispred_cnt_q;

   // Table registers; reset returns every entry to an invalid, weakly-not-taken state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
            jmp_q[i]    <= 1'b0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= valid_d[i];
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
            jmp_q[i]    <= jmp_d[i];
         end
      end
   end

   // Mispredict counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispred_cnt_q <= 16'd0;
      end else begin
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

endmodule

// File: tb/tb_bpred_btb.sv
// Directed bench for bpred_btb (XLEN=32, ENTRIES=16: index = pc[5:2], tag = pc[31:6]).
module tb_bpred_btb;

   logic        clk;
   logic        rst;
   logic        f_valid;
   logic [31:0] f_pc;
   logic        p_hit;
   logic        p_taken;
   logic [31:0] p_target;
   logic        u_valid;
   logic [31:0] u_pc;
   logic        u_is_branch;
   logic        u_is_jump;
   logic        u_taken;
   logic [31:0] u_target;
   logic        u_pred_taken;
   logic [31:0] u_pred_target;
   logic        u_mispredict;
   logic        flush_all;
   logic [15:0] mispred_cnt;

   int nvec;
   int nerr;
   logic [15:0] exp_cnt;

   bpred_btb #(.XLEN(32), .ENTRIES(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .f_valid       (f_valid),
      .f_pc          (f_pc),
      .p_hit         (p_hit),
      .p_taken       (p_taken),
      .p_target      (p_target),
      .u_valid       (u_valid),
      .u_pc          (u_pc),
      .u_is_branch   (u_is_branch),
      .u_is_jump     (u_is_jump),
      .u_taken       (u_taken),
      .u_target      (u_target),
      .u_pred_taken  (u_pred_taken),
      .u_pred_target (u_pred_target),
      .u_mispredict  (u_mispredict),
      .flush_all     (flush_all),
      .mispred_cnt   (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Combinational lookup check; does not advance the clock
   task automatic look(input string tag, input logic [31:0] pc, input logic eh,
                       input logic et, input logic [31:0] etgt);
      f_valid = 1'b1;
      f_pc    = pc;
      #1;
      chk({tag, ".hit"},    {31'd0, p_hit},   {31'd0, eh});
      chk({tag, ".taken"},  {31'd0, p_taken}, {31'd0, et});
      chk({tag, ".target"}, p_target,         etgt);
   endtask

   // One update cycle: checks u_mispredict before the edge, then clocks it in
   task automatic upd(input string tag, input logic [31:0] pc, input logic br, input logic jp,
                      input logic tk, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt, input logic fl, input logic emisp);
      u_valid       = 1'b1;
      u_pc          = pc;
      u_is_branch   = br;
      u_is_jump     = jp;
      u_taken       = tk;
      u_target      = tgt;
      u_pred_taken  = ptk;
      u_pred_target = ptgt;
      flush_all     = fl;
      #1;
      chk({tag, ".misp"}, {31'd0, u_mispredict}, {31'd0, emisp});
      if (emisp) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
      u_valid   = 1'b0;
      flush_all = 1'b0;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      exp_cnt = 16'd0;
      rst = 1'b1;
      f_valid = 1'b0;
      f_pc = 32'd0;
      u_valid = 1'b0;
      u_pc = 32'd0;
      u_is_branch = 1'b0;
      u_is_jump = 1'b0;
      u_taken = 1'b0;
      u_target = 32'd0;
      u_pred_taken = 1'b0;
      u_pred_target = 32'd0;
      flush_all = 1'b0;

      // Outputs while held in reset
      #1;
      look("rst_look", 32'h100, 1'b0, 1'b0, 32'h104);
      chk("rst_cnt", {16'd0, mispred_cnt}, 32'd0);
      chk("rst_misp", {31'd0, u_mispredict}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      look("empty_100", 32'h100, 1'b0, 1'b0, 32'h104);
      look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

      // Allocate branch 0x100 -> 0x80 (ctr 10), then weaken it
      upd("alloc_100", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
      look("hit_100", 32'h100, 1'b1, 1'b1, 32'h80);
      look("pc_lsbs", 32'h103, 1'b1, 1'b1, 32'h80);
      upd("nt1", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1);
      look("after_nt1", 32'h100, 1'b1, 1'b0, 32'h104);
      upd("nt2", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      look("after_nt2", 32'h100, 1'b1, 1'b0, 32'h104);
      // From 00 one taken update gives 01, still not taken (proves the floor)
      upd("t_from0", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
      look("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
      upd("t_to10", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
      look("ctr10", 32'h100, 1'b1, 1'b1, 32'h80);
      upd("t_to11", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
      upd("t_sat", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
      upd("nt_from11", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1);
      look("ctr_ceiling", 32'h100, 1'b1, 1'b1, 32'h80);
      chk("cnt_a", {16'd0, mispred_cnt}, {16'd0, exp_cnt});

      // Jump 0x200 evicts 0x100; aliasing branch 0x240 then evicts the jump
      upd("jal_200", 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b1);
      look("hit_200", 32'h200, 1'b1, 1'b1, 32'h400);
      look("evicted_100", 32'h100, 1'b0, 1'b0, 32'h104);
      upd("br_240", 32'h240, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1);
      look("miss_200", 32'h200, 1'b0, 1'b0, 32'h204);
      look("hit_240", 32'h240, 1'b1, 1'b1, 32'h10);
      // Correct direction, wrong target is still a mispredict; target rewritten
      upd("tgt_wrong", 32'h240, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h10, 1'b0, 1'b1);
      look("new_tgt", 32'h240, 1'b1, 1'b1, 32'h20);

      // Flush wins over a same-cycle update, which is still counted
      upd("flush_upd", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
      look("fl_100", 32'h100, 1'b0, 1'b0, 32'h104);
      look("fl_240", 32'h240, 1'b0, 1'b0, 32'h244);

      // Same-cycle lookup/update of 0x300: no bypass
      look("same_cyc", 32'h300, 1'b0, 1'b0, 32'h304);
      upd("upd_300", 32'h300, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b1);
      look("next_cyc", 32'h300, 1'b1, 1'b1, 32'h500);
      // Not-taken miss leaves the table alone
      upd("nt_miss", 32'h140, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      look("kept_300", 32'h300, 1'b1, 1'b1, 32'h500);
      // f_valid low suppresses the hit
      f_valid = 1'b0;
      #1;
      chk("fvalid_lo", {31'd0, p_hit}, 32'd0);
      // Jump hit on a branch entry retargets it
      upd("jmp_hit", 32'h300, 1'b0, 1'b1, 1'b1, 32'h600, 1'b1, 32'h500, 1'b0, 1'b1);
      look("jmp_300", 32'h300, 1'b1, 1'b1, 32'h600);
      // u_valid low never mispredicts
      u_pred_taken = 1'b1;
      u_taken = 1'b0;
      #1;
      chk("uvalid_lo", {31'd0, u_mispredict}, 32'd0);
      chk("cnt_b", {16'd0, mispred_cnt}, {16'd0, exp_cnt});

      // Reset asserted mid-update wins
      u_valid = 1'b1;
      u_pc = 32'h340;
      u_is_branch = 1'b1;
      u_is_jump = 1'b0;
      u_taken = 1'b1;
      u_target = 32'h700;
      u_pred_taken = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_hit", {31'd0, p_hit}, 32'd0);
      chk("rst_mid_cnt", {16'd0, mispred_cnt}, 32'd0);
      @(posedge clk);
      #1;
      u_valid = 1'b0;
      rst = 1'b0;
      look("post_rst_340", 32'h340, 1'b0, 1'b0, 32'h344);
      look("post_rst_300", 32'h300, 1'b0, 1'b0, 32'h304);

      // Counter saturation over 70000 consecutive mispredicts
      u_valid = 1'b1;
      u_is_branch = 1'b1;
      u_pc = 32'h380;
      u_pred_taken = 1'b1;
      u_taken = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("cnt_100", {16'd0, mispred_cnt}, 32'd100);
      repeat (69900) @(posedge clk);
      #1;
      chk("cnt_sat", {16'd0, mispred_cnt}, 32'h0000_FFFF);
      u_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("cnt_async_rst", {16'd0, mispred_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("cnt_after_rst", {16'd0, mispred_cnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
